// File: rtl/posit_pkg.sv
// posit_pkg: shared posit typedef, special-value helpers and result flag bit positions.
package posit_pkg;
    localparam int POSIT_N = 8;
    localparam int FLAG_NAR = 1;
    localparam int FLAG_ZERO = 0;
    typedef logic [POSIT_N-1:0] posit_t;
    function automatic logic [31:0] posit_nar(input int n);
        return 32'(1) << (n - 1);
    endfunction
    function automatic logic posit_is_zero(input logic [31:0] p);
        return p == '0;
    endfunction
    function automatic logic posit_is_nar(input logic [31:0] p, input int n);
        return p == posit_nar(n);
    endfunction
endpackage

// File: rtl/posit_mult_feeder_if.sv
// posit_mult_feeder_if: operand A/B and result valid/ready streams of the posit multiplier feeder.
interface posit_mult_feeder_if #(parameter int N = 8);
    logic [N-1:0] a_data;
    logic         a_valid;
    logic         a_ready;
    logic [N-1:0] b_data;
    logic         b_valid;
    logic         b_ready;
    logic [N-1:0] res_data;
    logic [1:0]   res_flags;
    logic         res_valid;
    logic         res_ready;
    modport master (
        output a_data, a_valid, b_data, b_valid, res_ready,
        input  a_ready, b_ready, res_data, res_flags, res_valid
    );
    modport slave (
        input  a_data, a_valid, b_data, b_valid, res_ready,
        output a_ready, b_ready, res_data, res_flags, res_valid
    );
endinterface

// File: rtl/posit_fifo.sv
// posit_fifo: DEPTH-entry operand FIFO with registered occupancy count and synchronous flush.
module posit_fifo #(
    parameter int N = 8,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [N-1:0] wdata,
    output logic [N-1:0] rdata,
    output logic         full,
    output logic         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          do_push, do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push & !full;
    assign do_pop  = pop & !empty;
    assign rdata   = mem[rptr];
    // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop) rptr <= rptr + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wptr] <= wdata;
    end
endmodule

// File: rtl/posit_mult_feeder.sv
// posit_mult_feeder: pairs two posit operand streams onto a registered multiplier stage and a result stream.
// Define POSIT_FEEDER_SPECIAL_EN to force NaR/zero results from operand classification.
module posit_mult_feeder import posit_pkg::*; #(
    parameter int N = 8,
    parameter int ES = 4,
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    posit_mult_feeder_if.slave bus,
    output logic [N-1:0]       mult_in1,
    output logic [N-1:0]       mult_in2,
    input  logic [N-1:0]       mult_out,
    output logic [31:0]        op_count
);
    logic         a_full, a_empty, b_full, b_empty;
    logic         s1_v, s2_adv, s1_load, res_valid;
    logic [N-1:0] a_head, b_head, res_data, s2_data;
    logic [1:0]   res_flags, s2_flags;
    // ES only configures the external multiplier; nothing here depends on a valid value.
    if (ES < 0) begin : g_es_unused
    end
    posit_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_a (
        .clk, .rst_n, .flush, .push(bus.a_valid), .pop(s1_load), .wdata(bus.a_data),
        .rdata(a_head), .full(a_full), .empty(a_empty)
    );
    posit_fifo #(.N(N), .DEPTH(DEPTH)) u_fifo_b (
        .clk, .rst_n, .flush, .push(bus.b_valid), .pop(s1_load), .wdata(bus.b_data),
        .rdata(b_head), .full(b_full), .empty(b_empty)
    );
    assign bus.a_ready   = !a_full;
    assign bus.b_ready   = !b_full;
    assign bus.res_data  = res_data;
    assign bus.res_flags = res_flags;
    assign bus.res_valid = res_valid;
    assign s2_adv  = s1_v & (!res_valid | bus.res_ready);
    assign s1_load = !a_empty & !b_empty & (!s1_v | s2_adv);
`ifdef POSIT_FEEDER_SPECIAL_EN
    logic s1_nar, s1_zero;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_nar  <= 1'b0;
            s1_zero <= 1'b0;
        end else if (s1_load) begin
            s1_nar  <= posit_is_nar(32'(a_head), N) | posit_is_nar(32'(b_head), N);
            s1_zero <= posit_is_zero(32'(a_head)) | posit_is_zero(32'(b_head));
        end
    end
    always_comb begin
        s2_flags = '0;
        s2_flags[FLAG_NAR] = s1_nar;
        s2_flags[FLAG_ZERO] = s1_zero & !s1_nar;
        s2_data = s1_nar ? N'(posit_nar(N)) : s1_zero ? '0 : mult_out;
    end
`else
    assign s2_data  = mult_out;
    assign s2_flags = 2'b00;
`endif
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v      <= 1'b0;
            mult_in1  <= '0;
            mult_in2  <= '0;
            res_valid <= 1'b0;
            res_data  <= '0;
            res_flags <= '0;
            op_count  <= '0;
        end else if (flush) begin
            s1_v      <= 1'b0;
            res_valid <= 1'b0;
        end else begin
            if (s1_load) begin
                mult_in1 <= a_head;
                mult_in2 <= b_head;
            end
            s1_v <= s1_load | (s1_v & !s2_adv);
            if (s2_adv) begin
                res_data  <= s2_data;
                res_flags <= s2_flags;
            end
            res_valid <= s2_adv | (res_valid & !bus.res_ready);
            if (res_valid && bus.res_ready) op_count <= op_count + 32'd1;
        end
    end
endmodule

// File: tb/tb_posit_mult_feeder.sv
// tb_posit_mult_feeder: scoreboard bench for posit_mult_feeder; a fixed asymmetric function stands in for Mult_Arithmetic.
module tb_posit_mult_feeder;
    logic        clk = 0, rst_n = 1, flush = 0;
    logic [7:0]  mult_in1, mult_in2, mult_out;
    logic [31:0] op_count;
    int          checks = 0, errors = 0;
    logic [7:0]  a_q[$], b_q[$];
    logic [9:0]  exp_q[$], got_q[$];

    posit_mult_feeder_if #(.N(8)) bus ();

    posit_mult_feeder #(.N(8), .ES(4), .DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .bus(bus),
        .mult_in1(mult_in1), .mult_in2(mult_in2), .mult_out(mult_out), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mul_ref(input logic [7:0] a, input logic [7:0] b);
        return 8'(a * 8'd5) ^ {b[3:0], b[7:4]};
    endfunction

    function automatic logic [9:0] exp_res(input logic [7:0] a, input logic [7:0] b);
`ifdef POSIT_FEEDER_SPECIAL_EN
        if (a == 8'h80 || b == 8'h80) return {2'b10, 8'h80};
        if (a == 8'h00 || b == 8'h00) return {2'b01, 8'h00};
`endif
        return {2'b00, mul_ref(a, b)};
    endfunction

    assign mult_out = mul_ref(mult_in1, mult_in2);

    always @(posedge clk) begin
        if (rst_n && !flush) begin
            if (bus.a_valid && bus.a_ready) a_q.push_back(bus.a_data);
            if (bus.b_valid && bus.b_ready) b_q.push_back(bus.b_data);
            if (bus.res_valid && bus.res_ready) got_q.push_back({bus.res_flags, bus.res_data});
            while (a_q.size() > 0 && b_q.size() > 0) exp_q.push_back(exp_res(a_q.pop_front(), b_q.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1);
    end

    task automatic clear_queues();
        a_q.delete(); b_q.delete(); exp_q.delete(); got_q.delete();
    endtask

    task automatic test_reset();
        #1 rst_n = 0;
        #1;
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got a=%b b=%b, expected 1 1", bus.a_ready, bus.b_ready);
        end
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 8'h00 || bus.res_flags !== 2'b00) begin
            errors++; $display("FAIL reset_result: got v=%b d=%h f=%b, expected 0 00 00", bus.res_valid, bus.res_data, bus.res_flags);
        end
        checks++;
        if (mult_in1 !== 8'h00 || mult_in2 !== 8'h00 || op_count !== 32'd0) begin
            errors++; $display("FAIL reset_regs: got in1=%h in2=%h cnt=%0d, expected 00 00 0", mult_in1, mult_in2, op_count);
        end
        @(negedge clk) rst_n = 1;
    endtask

    task automatic test_latency();
        logic [31:0] op0;
        logic [9:0] g, e;
        bus.res_ready = 1;
        @(negedge clk);
        op0 = op_count;
        bus.a_data = 8'h4D; bus.b_data = 8'h4E; bus.a_valid = 1; bus.b_valid = 1;
        @(negedge clk);
        bus.a_valid = 0; bus.b_valid = 0;
        checks++;
        if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL lat_e0_valid: got %b, expected 0", bus.res_valid); end
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b0 || mult_in1 !== 8'h4D || mult_in2 !== 8'h4E) begin
            errors++; $display("FAIL lat_s1: got v=%b in1=%h in2=%h, expected 0 4d 4e", bus.res_valid, mult_in1, mult_in2);
        end
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== mul_ref(8'h4D, 8'h4E) || bus.res_flags !== 2'b00) begin
            errors++; $display("FAIL lat_e2: got v=%b d=%h f=%b, expected 1 %h 00", bus.res_valid, bus.res_data, bus.res_flags, mul_ref(8'h4D, 8'h4E));
        end
        @(negedge clk);
        checks++;
        if (op_count !== op0 + 32'd1) begin errors++; $display("FAIL lat_count: got %0d, expected %0d", op_count, op0 + 32'd1); end
        checks++;
        if (got_q.size() != 1) begin errors++; $display("FAIL lat_results: got %0d results, expected 1", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL lat_data: got %h, expected %h", g, e); end
        end
        clear_queues();
    endtask

    task automatic test_back_to_back();
        int w;
        logic [9:0] g, e;
        bus.res_ready = 1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
                errors++; $display("FAIL b2b_ready[%0d]: got a=%b b=%b, expected 1 1", i, bus.a_ready, bus.b_ready);
            end
            bus.a_data = 8'($urandom_range(1, 127)); bus.b_data = 8'($urandom_range(1, 127));
            bus.a_valid = 1; bus.b_valid = 1;
        end
        @(negedge clk);
        bus.a_valid = 0; bus.b_valid = 0;
        for (w = 0; w < 40 && got_q.size() < 8; w++) @(negedge clk);
        checks++;
        if (got_q.size() != 8 || w > 3) begin
            errors++; $display("FAIL b2b_throughput: got %0d results after %0d extra cycles, expected 8 within 3", got_q.size(), w);
        end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL b2b_data: got %h, expected %h", g, e); end
        end
        clear_queues();
    endtask

    task automatic test_backpressure();
        logic [31:0] op0;
        logic [9:0] g, e;
        bus.res_ready = 0;
        op0 = op_count;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            if (i == 6) begin
                checks++;
                if (bus.a_ready !== 1'b0 || bus.b_ready !== 1'b0) begin
                    errors++; $display("FAIL bp_full: got a=%b b=%b, expected 0 0", bus.a_ready, bus.b_ready);
                end
            end
            bus.a_data = 8'(8'h10 + i); bus.b_data = 8'(8'h21 + 2 * i);
            bus.a_valid = 1; bus.b_valid = 1;
        end
        @(negedge clk);
        bus.a_valid = 0; bus.b_valid = 0;
        bus.res_ready = 1;
        for (int w = 0; w < 40 && got_q.size() < 7; w++) @(negedge clk);
        checks++;
        if (got_q.size() != 6) begin errors++; $display("FAIL bp_results: got %0d results, expected 6", got_q.size()); end
        checks++;
        if (op_count !== op0 + 32'd6) begin errors++; $display("FAIL bp_count: got %0d, expected %0d", op_count, op0 + 32'd6); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL bp_data: got %h, expected %h", g, e); end
        end
        clear_queues();
    endtask

    task automatic test_skew();
        logic early;
        logic [9:0] g, e;
        bus.res_ready = 1;
        early = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.a_data = 8'(8'h11 * (i + 1)); bus.a_valid = 1;
        end
        @(negedge clk);
        bus.a_valid = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0) early = 1;
        end
        checks++;
        if (early) begin errors++; $display("FAIL skew_early: got res_valid=1 before any B, expected 0"); end
        for (int i = 0; i < 3; i++) begin
            bus.b_data = 8'(8'h23 + i); bus.b_valid = 1;
            @(negedge clk);
        end
        bus.b_valid = 0;
        for (int w = 0; w < 40 && got_q.size() < 3; w++) @(negedge clk);
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL skew_results: got %0d results, expected 3", got_q.size()); end
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL skew_data: got %h, expected %h", g, e); end
        end
        clear_queues();
    endtask

`ifdef POSIT_FEEDER_SPECIAL_EN
    task automatic test_special();
        logic [7:0] av[3] = '{8'h80, 8'h00, 8'h80};
        logic [7:0] bv[3] = '{8'h40, 8'h40, 8'h00};
        logic [9:0] want[3] = '{{2'b10, 8'h80}, {2'b01, 8'h00}, {2'b10, 8'h80}};
        logic [9:0] g;
        bus.res_ready = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.a_data = av[i]; bus.b_data = bv[i]; bus.a_valid = 1; bus.b_valid = 1;
        end
        @(negedge clk);
        bus.a_valid = 0; bus.b_valid = 0;
        for (int w = 0; w < 40 && got_q.size() < 3; w++) @(negedge clk);
        checks++;
        if (got_q.size() != 3) begin errors++; $display("FAIL special_results: got %0d results, expected 3", got_q.size()); end
        for (int i = 0; i < 3 && got_q.size() > 0; i++) begin
            g = got_q.pop_front();
            checks++;
            if (g !== want[i]) begin errors++; $display("FAIL special_data[%0d]: got %h, expected %h", i, g, want[i]); end
        end
        clear_queues();
    endtask
`endif

    task automatic test_flush();
        logic [31:0] op0;
        logic seen;
        bus.res_ready = 0;
        op0 = op_count;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.a_data = 8'(8'h60 + i); bus.b_data = 8'(8'h31 + i); bus.a_valid = 1; bus.b_valid = 1;
        end
        @(negedge clk);
        flush = 1;
        bus.a_data = 8'h77; bus.b_data = 8'h66;
        @(negedge clk);
        flush = 0; bus.a_valid = 0; bus.b_valid = 0;
        checks++;
        if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b, expected 0", bus.res_valid); end
        checks++;
        if (bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
            errors++; $display("FAIL flush_ready: got a=%b b=%b, expected 1 1", bus.a_ready, bus.b_ready);
        end
        checks++;
        if (op_count !== op0) begin errors++; $display("FAIL flush_count: got %0d, expected %0d", op_count, op0); end
        clear_queues();
        bus.res_ready = 1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.res_valid !== 1'b0) seen = 1;
        end
        checks++;
        if (seen) begin errors++; $display("FAIL flush_residue: got a result after flush, expected none"); end
        clear_queues();
    endtask

    task automatic test_reset_mid();
        logic [9:0] g, e;
        bus.res_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.a_data = 8'(8'h45 + i); bus.b_data = 8'(8'h19 + i); bus.a_valid = 1; bus.b_valid = 1;
        end
        @(negedge clk);
        bus.a_valid = 0; bus.b_valid = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 0;
        #1;
        checks++;
        if (bus.res_valid !== 1'b0 || bus.res_data !== 8'h00 || bus.res_flags !== 2'b00 || op_count !== 32'd0) begin
            errors++; $display("FAIL rstmid_result: got v=%b d=%h f=%b cnt=%0d, expected 0 00 00 0", bus.res_valid, bus.res_data, bus.res_flags, op_count);
        end
        checks++;
        if (mult_in1 !== 8'h00 || mult_in2 !== 8'h00 || bus.a_ready !== 1'b1 || bus.b_ready !== 1'b1) begin
            errors++; $display("FAIL rstmid_regs: got in1=%h in2=%h a_rdy=%b b_rdy=%b, expected 00 00 1 1", mult_in1, mult_in2, bus.a_ready, bus.b_ready);
        end
        clear_queues();
        @(negedge clk) rst_n = 1;
        @(negedge clk);
        bus.res_ready = 1;
        bus.a_data = 8'h3C; bus.b_data = 8'h5A; bus.a_valid = 1; bus.b_valid = 1;
        @(negedge clk);
        bus.a_valid = 0; bus.b_valid = 0;
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b0) begin errors++; $display("FAIL rstmid_early: got %b, expected 0", bus.res_valid); end
        @(negedge clk);
        checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== mul_ref(8'h3C, 8'h5A)) begin
            errors++; $display("FAIL rstmid_after: got v=%b d=%h, expected 1 %h", bus.res_valid, bus.res_data, mul_ref(8'h3C, 8'h5A));
        end
        for (int w = 0; w < 40 && got_q.size() < 1; w++) @(negedge clk);
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            g = got_q.pop_front(); e = exp_q.pop_front();
            checks++;
            if (g !== e) begin errors++; $display("FAIL rstmid_data: got %h, expected %h", g, e); end
        end
        clear_queues();
    endtask

    initial begin
        bus.a_data = 0; bus.a_valid = 0; bus.b_data = 0; bus.b_valid = 0; bus.res_ready = 0;
        test_reset();
        test_latency();
        test_back_to_back();
        test_backpressure();
        test_skew();
`ifdef POSIT_FEEDER_SPECIAL_EN
        test_special();
`endif
        test_flush();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
